// File: rtl/hotspot_ctrl_pkg.sv
// Shared register-map constants and bit positions for the hotspot control/status register file.
package hotspot_ctrl_pkg;

    localparam int ADDR_CTRL     = 0;
    localparam int ADDR_STATUS   = 1;
    localparam int ADDR_ROWS     = 2;
    localparam int ADDR_COLS     = 3;
    localparam int ADDR_ITERS    = 4;
    localparam int ADDR_CYCLES   = 5;
    localparam int ADDR_VERSION  = 6;
    localparam int ADDR_SCRATCH0 = 7;

    localparam int SCRATCH_DEPTH = 25;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_REJ_BIT  = 2;

    localparam logic [31:0] VERSION_DEFAULT = 32'h4853_0001;

endpackage

// File: rtl/hotspot_ctrl_scratch_ram.sv
// 25 x 32 scratch storage: one synchronous write port, one combinational read port.
module hotspot_ctrl_scratch_ram
    import hotspot_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [SCRATCH_DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SCRATCH_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (32'(waddr_i) < SCRATCH_DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (32'(raddr_i) < SCRATCH_DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/hotspot_ctrl_regs.sv
// Host-visible control/status registers for the hotspot kernel, bridged to Xillybus xcw/xcr seekable streams.
module hotspot_ctrl_regs
    import hotspot_ctrl_pkg::*;
#(
    parameter int          ADDR_W  = 5,
    parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
    input  logic              bus_clk,
    input  logic              reset,
    input  logic              user_w_xcw_ctrl_open,
    input  logic              user_w_xcw_ctrl_wren,
    input  logic [31:0]       user_w_xcw_ctrl_data,
    output logic              user_w_xcw_ctrl_full,
    input  logic [ADDR_W-1:0] user_xcw_ctrl_addr,
    input  logic              user_xcw_ctrl_addr_update,
    input  logic              user_r_xcr_ctrl_open,
    input  logic              user_r_xcr_ctrl_rden,
    output logic [31:0]       user_r_xcr_ctrl_data,
    output logic              user_r_xcr_ctrl_empty,
    output logic              user_r_xcr_ctrl_eof,
    input  logic [ADDR_W-1:0] user_xcr_ctrl_addr,
    input  logic              user_xcr_ctrl_addr_update,
    output logic [15:0]       kern_rows,
    output logic [15:0]       kern_cols,
    output logic [15:0]       kern_iters,
    output logic              kern_start,
    input  logic              kern_busy,
    input  logic              kern_done
);

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [15:0]       rows_q, cols_q, iters_q;
    logic [31:0]       cycles_q, cycles_d, rdata_q, rdata_d, rmux, scr_rdata;
    logic              running_q, running_d, done_q, done_d, rej_q, rej_d;
    logic              start_q, start_d, upd_q;
    logic              wr_en, rd_en, ctrl_wr, busy, empty;
    logic [2:0]        status;
    int                wa, ra;

    assign wa      = 32'(wr_addr_q);
    assign ra      = 32'(rd_addr_q);
    assign wr_en   = user_w_xcw_ctrl_open && user_w_xcw_ctrl_wren;
    assign ctrl_wr = wr_en && (wa == ADDR_CTRL);
    assign busy    = kern_busy || running_q;
    // Empty covers the seek cycle and the one after, so the host never sees data from a stale address.
    assign empty   = !user_r_xcr_ctrl_open || user_xcr_ctrl_addr_update || upd_q;
    assign rd_en   = user_r_xcr_ctrl_rden && !empty;

    always_comb begin
        status                = '0;
        status[STAT_BUSY_BIT] = busy;
        status[STAT_DONE_BIT] = done_q;
        status[STAT_REJ_BIT]  = rej_q;
    end

    always_comb begin
        wr_addr_d = wr_addr_q;
        if (!user_w_xcw_ctrl_open)          wr_addr_d = '0;
        else if (user_xcw_ctrl_addr_update) wr_addr_d = user_xcw_ctrl_addr;
        else if (user_w_xcw_ctrl_wren)      wr_addr_d = wr_addr_q + ADDR_W'(1);

        rd_addr_d = rd_addr_q;
        if (!user_r_xcr_ctrl_open)          rd_addr_d = '0;
        else if (user_xcr_ctrl_addr_update) rd_addr_d = user_xcr_ctrl_addr;
        else if (rd_en)                     rd_addr_d = rd_addr_q + ADDR_W'(1);
    end

    // Ordering: sticky clear, then kernel completion, then start/reject.
    always_comb begin
        running_d = running_q;
        done_d    = done_q;
        rej_d     = rej_q;
        start_d   = 1'b0;
        cycles_d  = cycles_q;
        if (running_q && !kern_done && (cycles_q != '1)) cycles_d = cycles_q + 32'd1;
        if (ctrl_wr && user_w_xcw_ctrl_data[CTRL_CLEAR_BIT]) begin
            done_d = 1'b0;
            rej_d  = 1'b0;
        end
        if (kern_done) begin
            running_d = 1'b0;
            done_d    = 1'b1;
        end
        if (ctrl_wr && user_w_xcw_ctrl_data[CTRL_START_BIT]) begin
            if (!busy) begin
                start_d   = 1'b1;
                running_d = 1'b1;
                cycles_d  = '0;
                done_d    = 1'b0;
            end else begin
                rej_d = 1'b1;
            end
        end
    end

    always_comb begin
        rmux = '0;
        case (ra)
            ADDR_CTRL:    rmux = '0;
            ADDR_STATUS:  rmux = 32'(status);
            ADDR_ROWS:    rmux = {16'h0, rows_q};
            ADDR_COLS:    rmux = {16'h0, cols_q};
            ADDR_ITERS:   rmux = {16'h0, iters_q};
            ADDR_CYCLES:  rmux = cycles_q;
            ADDR_VERSION: rmux = VERSION;
            default:      rmux = scr_rdata;
        endcase
        rdata_d = rd_en ? rmux : rdata_q;
    end

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            iters_q   <= '0;
            cycles_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            rej_q     <= 1'b0;
            start_q   <= 1'b0;
            upd_q     <= 1'b1;
            rdata_q   <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            cycles_q  <= cycles_d;
            running_q <= running_d;
            done_q    <= done_d;
            rej_q     <= rej_d;
            start_q   <= start_d;
            upd_q     <= user_xcr_ctrl_addr_update;
            rdata_q   <= rdata_d;
            if (wr_en && (wa == ADDR_ROWS))  rows_q  <= user_w_xcw_ctrl_data[15:0];
            if (wr_en && (wa == ADDR_COLS))  cols_q  <= user_w_xcw_ctrl_data[15:0];
            if (wr_en && (wa == ADDR_ITERS)) iters_q <= user_w_xcw_ctrl_data[15:0];
        end
    end

    hotspot_ctrl_scratch_ram #(.ADDR_W(ADDR_W)) u_scratch (
        .clk_i   (bus_clk),
        .rst_i   (reset),
        .we_i    (wr_en && (wa >= ADDR_SCRATCH0)),
        .waddr_i (wr_addr_q - ADDR_W'(ADDR_SCRATCH0)),
        .wdata_i (user_w_xcw_ctrl_data),
        .raddr_i (rd_addr_q - ADDR_W'(ADDR_SCRATCH0)),
        .rdata_o (scr_rdata)
    );

    assign user_w_xcw_ctrl_full  = 1'b0;
    assign user_r_xcr_ctrl_eof   = 1'b0;
    assign user_r_xcr_ctrl_empty = empty;
    assign user_r_xcr_ctrl_data  = rdata_q;
    assign kern_rows             = rows_q;
    assign kern_cols             = cols_q;
    assign kern_iters            = iters_q;
    assign kern_start            = start_q;

endmodule
